// File: rtl/decode_stage.sv
// RV-style instruction decode stage: classifies the format and extracts fields and the sign-extended immediate.
// Latency: 1 cycle from acceptance to out_* when the output register is empty or drains in the same cycle.
// Backpressure: output register plus one skid entry; in_ready drops only when the skid entry is occupied.
module decode_stage #(
   parameter int XLEN      = 32,
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [PC_WIDTH-1:0]  in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PC_WIDTH-1:0]  out_pc,
   output logic [2:0]           out_fmt,
   output logic [6:0]           out_opcode,
   output logic [2:0]           out_funct3,
   output logic [6:0]           out_funct7,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [4:0]           out_rd,
   output logic                 out_imm_valid,
   output logic [XLEN-1:0]      out_imm,
   output logic [CNT_WIDTH-1:0] illegal_count
);

   // Only RV32 and RV64 datapaths exist; anything else must stop the build.
   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam bit IS_RV64 = (XLEN == 64);

   // One decoded entry, as held in the output register and the skid slot.
   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [2:0]          fmt;
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic                imm_valid;
      logic [XLEN-1:0]     imm;
   } entry_t;

   // Widen a 32-bit immediate (already sign-filled to bit 31) to the datapath width.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [4:0]  op5;
   logic [2:0]  fmt;
   logic [31:0] imm32;
   entry_t      dec;

   entry_t out_q;
   entry_t skid_q;
   logic   out_vld_q;
   logic   skid_vld_q;
   logic   [CNT_WIDTH-1:0] cnt_q;

   logic accept;
   logic xfer;

   // Format classification from the major opcode; low bits other than 11 are compressed/illegal.
   always_comb begin
      op5 = in_instr[6:2];
      fmt = FMT_ILL;
      if (in_instr[1:0] == 2'b11) begin
         case (op5)
            5'b01100: fmt = FMT_R;
            5'b01110: fmt = IS_RV64 ? FMT_R : FMT_ILL;
            5'b00000,
            5'b00011,
            5'b00100,
            5'b11001,
            5'b11100: fmt = FMT_I;
            5'b00110: fmt = IS_RV64 ? FMT_I : FMT_ILL;
            5'b01000: fmt = FMT_S;
            5'b11000: fmt = FMT_B;
            5'b00101,
            5'b01101: fmt = FMT_U;
            5'b11011: fmt = FMT_J;
            default:  fmt = FMT_ILL;
         endcase
      end
   end

   // Field extraction: only the fields a format actually carries are passed, the rest stay zero.
   always_comb begin
      dec     = '0;
      imm32   = '0;
      dec.pc  = in_pc;
      dec.fmt = fmt;
      case (fmt)
         FMT_R: begin
            dec.funct3 = in_instr[14:12];
            dec.funct7 = in_instr[31:25];
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            dec.rd     = in_instr[11:7];
         end
         FMT_I: begin
            dec.funct3 = in_instr[14:12];
            dec.funct7 = in_instr[31:25];
            dec.rs1    = in_instr[19:15];
            dec.rd     = in_instr[11:7];
            imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         FMT_S: begin
            dec.funct3 = in_instr[14:12];
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         FMT_B: begin
            dec.funct3 = in_instr[14:12];
            dec.rs1    = in_instr[19:15];
            dec.rs2    = in_instr[24:20];
            imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
         end
         FMT_U: begin
            dec.rd     = in_instr[11:7];
            imm32      = {in_instr[31:12], 12'b0};
         end
         FMT_J: begin
            dec.rd     = in_instr[11:7];
            imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
         end
         default: ;
      endcase
      if (fmt != FMT_ILL) begin
         dec.opcode = in_instr[6:0];
      end
      dec.imm_valid = (fmt != FMT_ILL) && (fmt != FMT_R);
      dec.imm       = dec.imm_valid ? sext32(imm32) : '0;
   end

   // Handshake qualifiers; flush takes priority inside the register process.
   always_comb begin
      accept = in_valid && !skid_vld_q;
      xfer   = out_vld_q && out_ready;
   end

   // Two-entry pipeline buffer: new data goes straight to the output unless it is stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else if (flush) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else if (skid_vld_q) begin
         // in_ready is low here, so only the drain of the skid entry can happen
         if (out_ready) begin
            out_q      <= skid_q;
            skid_vld_q <= 1'b0;
         end
      end else if (accept) begin
         if (!out_vld_q || out_ready) begin
            out_q     <= dec;
            out_vld_q <= 1'b1;
         end else begin
            skid_q     <= dec;
            skid_vld_q <= 1'b1;
         end
      end else if (xfer) begin
         out_vld_q <= 1'b0;
      end
   end

   // Saturating count of illegal entries handed to the consumer; flushed transfers do not count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (!flush && xfer && (out_q.fmt == FMT_ILL) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign in_ready      = !skid_vld_q;
   assign out_valid     = out_vld_q;
   assign out_pc        = out_q.pc;
   assign out_fmt       = out_q.fmt;
   assign out_opcode    = out_q.opcode;
   assign out_funct3    = out_q.funct3;
   assign out_funct7    = out_q.funct7;
   assign out_rs1       = out_q.rs1;
   assign out_rs2       = out_q.rs2;
   assign out_rd        = out_q.rd;
   assign out_imm_valid = out_q.imm_valid;
   assign out_imm       = out_q.imm;
   assign illegal_count = cnt_q;

endmodule
